// File: rtl/ddi_phase_sequencer.sv
// ddi_phase_sequencer
//   Sequences N_PHASES signal phases through GREEN -> YELLOW -> ALL_RED, with
//   all timing counted in ticks of an external enable. Requests are latched
//   per phase. Green runs for at least GREEN_MIN and at most GREEN_MAX ticks,
//   and ends early once another phase is waiting. The next phase is chosen
//   round-robin, skipping ahead to the first waiting phase. A maintenance
//   request parks the junction in a RED/DARK flash once the current cycle has
//   cleared safely.
//
// Ports
//   clk            in   1         system clock, rising edge
//   rst            in   1         asynchronous, active-high reset
//   tick           in   1         timing enable; timers and state advance only when high
//   maintenance    in   1         level request for flash mode
//   req            in   N_PHASES  per-phase service request (level or pulse)
//   current_phase  out  PHASE_W   phase currently or last served
//   light_state    out  2         00=RED 01=GREEN 10=YELLOW 11=DARK
//   pending        out  N_PHASES  latched request register
//   green_start    out  1         one-cycle pulse on each entry to GREEN
module ddi_phase_sequencer #(
  parameter int N_PHASES  = 4,
  parameter int PHASE_W   = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int FLASH_T   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                maintenance,
  input  logic [N_PHASES-1:0] req,
  output logic [PHASE_W-1:0]  current_phase,
  output logic [1:0]          light_state,
  output logic [N_PHASES-1:0] pending,
  output logic                green_start
);

  typedef enum logic [2:0] {
    S_ALL_RED   = 3'd0,
    S_GREEN     = 3'd1,
    S_YELLOW    = 3'd2,
    S_FLASH_ON  = 3'd3,
    S_FLASH_OFF = 3'd4
  } state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_DARK   = 2'b11;

  // Timer value on the last tick of each state (a state of length T exits at T-1).
  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST     = CNT_W'(FLASH_T - 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      timer, timer_next;
  logic [PHASE_W-1:0]    phase_next, rr_phase, scan_idx;
  logic [N_PHASES-1:0]   pending_next, set_mask;
  logic [1:0]            light_next;
  logic                  green_start_next, other_pending, found;

  function automatic logic [N_PHASES-1:0] phase_onehot(input logic [PHASE_W-1:0] p);
    logic [N_PHASES-1:0] m;
    m = '0;
    for (int k = 0; k < N_PHASES; k++) begin
      if (PHASE_W'(k) == p) m[k] = 1'b1;
      else                  m[k] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [1:0] light_of(input state_t s);
    logic [1:0] l;
    case (s)
      S_GREEN:     l = LIGHT_GREEN;
      S_YELLOW:    l = LIGHT_YELLOW;
      S_FLASH_OFF: l = LIGHT_DARK;
      S_ALL_RED:   l = LIGHT_RED;
      S_FLASH_ON:  l = LIGHT_RED;
      default:     l = LIGHT_RED;
    endcase
    return l;
  endfunction

  // Round-robin pick: first pending phase after current_phase (the current
  // phase itself is checked last); plain successor when nothing is pending.
  always_comb begin
    rr_phase = PHASE_W'((int'(current_phase) + 1) % N_PHASES);
    scan_idx = '0;
    found    = 1'b0;
    for (int i = 1; i <= N_PHASES; i++) begin
      scan_idx = PHASE_W'((int'(current_phase) + i) % N_PHASES);
      if (!found && pending[scan_idx]) begin
        rr_phase = scan_idx;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    other_pending = |(pending & ~phase_onehot(current_phase));
  end

  // Next-state, timer, pending and output decode.
  always_comb begin
    state_next       = state;
    phase_next       = current_phase;
    green_start_next = 1'b0;

    case (state)
      S_ALL_RED: begin
        if (tick && timer == ALLRED_LAST) begin
          if (maintenance) begin
            state_next = S_FLASH_ON;
          end else begin
            state_next       = S_GREEN;
            phase_next       = rr_phase;
            green_start_next = 1'b1;
          end
        end else begin
          state_next = S_ALL_RED;
        end
      end
      S_GREEN: begin
        // Maintenance ends green at the next tick, bypassing GREEN_MIN.
        if (tick && (timer == GREEN_MAX_LAST || maintenance ||
                     (timer >= GREEN_MIN_LAST && other_pending))) begin
          state_next = S_YELLOW;
        end else begin
          state_next = S_GREEN;
        end
      end
      S_YELLOW: begin
        if (tick && timer == YELLOW_LAST) state_next = S_ALL_RED;
        else                              state_next = S_YELLOW;
      end
      S_FLASH_ON: begin
        if (tick && timer == FLASH_LAST) state_next = maintenance ? S_FLASH_OFF : S_ALL_RED;
        else                             state_next = S_FLASH_ON;
      end
      S_FLASH_OFF: begin
        if (tick && timer == FLASH_LAST) state_next = maintenance ? S_FLASH_ON : S_ALL_RED;
        else                             state_next = S_FLASH_OFF;
      end
      default: begin
        state_next = S_ALL_RED;
      end
    endcase

    // Any state change (including flash half-period flips) restarts the timer.
    if (state_next != state) timer_next = '0;
    else if (tick)           timer_next = timer + CNT_W'(1);
    else                     timer_next = timer;

    // Requests are ignored in flash, and for the phase that is already green.
    if (state == S_FLASH_ON || state == S_FLASH_OFF) set_mask = '0;
    else if (state == S_GREEN)                       set_mask = req & ~phase_onehot(current_phase);
    else                                             set_mask = req;

    // Clears are applied after sets so a coincident clear wins.
    pending_next = pending | set_mask;
    if (state == S_ALL_RED && state_next == S_FLASH_ON) pending_next = '0;
    else if (green_start_next)                          pending_next = pending_next & ~phase_onehot(phase_next);
    else                                                pending_next = pending_next;

    light_next = light_of(state_next);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_ALL_RED;
      timer         <= '0;
      current_phase <= PHASE_W'(N_PHASES - 1);
      light_state   <= LIGHT_RED;
      pending       <= '0;
      green_start   <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      current_phase <= phase_next;
      light_state   <= light_next;
      pending       <= pending_next;
      green_start   <= green_start_next;
    end
  end

endmodule

// File: tb/tb_ddi_phase_sequencer.sv
`timescale 1ns/1ps
module tb_ddi_phase_sequencer;
  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_GREEN  = 2'b01;
  localparam logic [1:0] L_YELLOW = 2'b10;
  localparam logic [1:0] L_DARK   = 2'b11;

  logic       clk = 1'b0;
  logic       rst, tick, maintenance;
  logic [3:0] req;
  logic [1:0] current_phase, light_state;
  logic [3:0] pending;
  logic       green_start;

  int n_checks = 0;
  int n_fails  = 0;

  // One expected light segment: a run of constant (light, phase).
  typedef struct {
    logic [1:0] light;
    logic [1:0] phase;
    int         ticks;
    int         clocks;
    int         gs;
  } seg_t;
  seg_t exp_q[$];

  always #5 clk = ~clk;

  ddi_phase_sequencer #(
    .N_PHASES(4), .PHASE_W(2), .CNT_W(8), .GREEN_MIN(3), .GREEN_MAX(6),
    .YELLOW_T(2), .ALLRED_T(1), .FLASH_T(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .maintenance(maintenance), .req(req),
    .current_phase(current_phase), .light_state(light_state),
    .pending(pending), .green_start(green_start)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seg(input logic [1:0] l, input logic [1:0] p, input int t, input int c);
    seg_t s;
    s.light  = l;
    s.phase  = p;
    s.ticks  = t;
    s.clocks = c;
    s.gs     = (l == L_GREEN) ? 1 : 0;
    exp_q.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_green(input logic [1:0] p);
    int n;
    n = 0;
    step();
    while (!(green_start === 1'b1 && current_phase === p) && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fails++;
      $display("FAIL wait_green: no green_start for phase %0d within 200 clocks", p);
    end
  endtask

  // tick on every third clock, starting with two idle clocks
  task automatic run3(input int n);
    for (int k = 0; k < n; k++) begin
      tick = ((k % 3) == 2);
      step();
    end
  endtask

  // Monitor: closes a segment when (light, phase) changes and checks it
  // against the head of the expected queue.
  initial begin : monitor
    seg_t cur;
    seg_t e;
    bit   in_seg;
    in_seg = 1'b0;
    cur.light = 2'b00; cur.phase = 2'b00; cur.ticks = 0; cur.clocks = 0; cur.gs = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        in_seg = 1'b0;
      end else begin
        if (in_seg && (light_state !== cur.light || current_phase !== cur.phase)) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL segment: got light=%0d phase=%0d ticks=%0d, none expected",
                     cur.light, cur.phase, cur.ticks);
          end else begin
            e = exp_q.pop_front();
            if (cur.light !== e.light || cur.phase !== e.phase || cur.ticks != e.ticks ||
                cur.clocks != e.clocks || cur.gs != e.gs) begin
              n_fails++;
              $display("FAIL segment: got light=%0d phase=%0d ticks=%0d clocks=%0d gs=%0d, expected light=%0d phase=%0d ticks=%0d clocks=%0d gs=%0d",
                       cur.light, cur.phase, cur.ticks, cur.clocks, cur.gs,
                       e.light, e.phase, e.ticks, e.clocks, e.gs);
            end
          end
          in_seg = 1'b0;
        end
        if (!in_seg) begin
          cur.light = light_state; cur.phase = current_phase;
          cur.ticks = 0; cur.clocks = 0; cur.gs = 0;
          in_seg = 1'b1;
        end
        cur.clocks++;
        if (tick === 1'b1) cur.ticks++;
        if (green_start === 1'b1) cur.gs++;
      end
    end
  end

  initial begin : stimulus
    int n;
    rst = 1'b1; tick = 1'b1; maintenance = 1'b0; req = 4'b0000;
    #1;
    check("reset_light", 32'(light_state), 32'(L_RED));
    check("reset_phase", 32'(current_phase), 32'd3);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_green_start", 32'(green_start), 32'd0);
    step(); step();

    // 1: free-running round robin 0,1,2,3,0
    push_seg(L_RED, 2'd3, 1, 1);
    for (int p = 0; p < 4; p++) begin
      push_seg(L_GREEN, 2'(p), 6, 6);
      push_seg(L_YELLOW, 2'(p), 2, 2);
      push_seg(L_RED, 2'(p), 1, 1);
    end
    rst = 1'b0;
    wait_green(2'd0);
    wait_green(2'd0);

    // 2: req[2] pulse at green timer 0 -> gap-out after 3 ticks, skip to phase 2
    push_seg(L_GREEN, 2'd0, 3, 3); push_seg(L_YELLOW, 2'd0, 2, 2); push_seg(L_RED, 2'd0, 1, 1);
    push_seg(L_GREEN, 2'd2, 6, 6); push_seg(L_YELLOW, 2'd2, 2, 2); push_seg(L_RED, 2'd2, 1, 1);
    push_seg(L_GREEN, 2'd3, 6, 6); push_seg(L_YELLOW, 2'd3, 2, 2); push_seg(L_RED, 2'd3, 1, 1);
    req = 4'b0100;
    step();
    req = 4'b0000;
    check("skip_pending_set", 32'(pending), 32'h4);
    wait_green(2'd2);
    check("skip_pending_cleared", 32'(pending), 32'h0);

    // 3: own-phase request during green is ignored
    wait_green(2'd0);
    push_seg(L_GREEN, 2'd0, 6, 6); push_seg(L_YELLOW, 2'd0, 2, 2); push_seg(L_RED, 2'd0, 1, 1);
    req = 4'b0001;
    repeat (5) step();
    check("own_req_ignored", 32'(pending), 32'h0);
    req = 4'b0000;

    // 4: maintenance at green timer 1, flash, req ignored, release
    wait_green(2'd1);
    push_seg(L_GREEN, 2'd1, 2, 2); push_seg(L_YELLOW, 2'd1, 2, 2);
    push_seg(L_RED, 2'd1, 3, 3);   push_seg(L_DARK, 2'd1, 2, 2);
    push_seg(L_RED, 2'd1, 2, 2);   push_seg(L_DARK, 2'd1, 2, 2);
    push_seg(L_RED, 2'd1, 1, 1);
    push_seg(L_GREEN, 2'd2, 6, 6); push_seg(L_YELLOW, 2'd2, 2, 2); push_seg(L_RED, 2'd2, 1, 1);
    step();
    maintenance = 1'b1;
    repeat (6) step();
    req = 4'b1000;
    step();
    req = 4'b0000;
    check("flash_req_ignored", 32'(pending), 32'h0);
    check("flash_light_dark", 32'(light_state), 32'(L_DARK));
    repeat (3) step();
    maintenance = 1'b0;
    wait_green(2'd2);

    // 5: tick every third clock, 20-clock freeze mid-yellow
    wait_green(2'd3);
    push_seg(L_GREEN, 2'd3, 6, 18); push_seg(L_YELLOW, 2'd3, 2, 26); push_seg(L_RED, 2'd3, 1, 3);
    push_seg(L_GREEN, 2'd0, 6, 18); push_seg(L_YELLOW, 2'd0, 2, 6);  push_seg(L_RED, 2'd0, 1, 3);
    run3(18);
    run3(3);
    tick = 1'b0;
    repeat (20) step();
    check("freeze_light", 32'(light_state), 32'(L_YELLOW));
    check("freeze_phase", 32'(current_phase), 32'd3);
    run3(3);
    run3(3);
    run3(18);
    run3(6);
    run3(3);
    tick = 1'b1;

    // 6: asynchronous reset mid-yellow
    push_seg(L_GREEN, 2'd1, 6, 6);
    repeat (7) step();
    check("pre_reset_light", 32'(light_state), 32'(L_YELLOW));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_light", 32'(light_state), 32'(L_RED));
    check("async_reset_phase", 32'(current_phase), 32'd3);
    check("async_reset_pending", 32'(pending), 32'd0);
    check("async_reset_green_start", 32'(green_start), 32'd0);
    step(); step();
    push_seg(L_RED, 2'd3, 1, 1);
    push_seg(L_GREEN, 2'd0, 6, 6); push_seg(L_YELLOW, 2'd0, 2, 2); push_seg(L_RED, 2'd0, 1, 1);
    rst = 1'b0;
    wait_green(2'd0);
    wait_green(2'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
